cordic_arbiter: RTL and testbench
=================================

Name: cordic_arbiter

Overview:
- Shares one cordic instance between NB_REQ independent requesters.
- Arbitration is round-robin over valid/ready input channels.
- Accepted (re, im) pairs go to the cordic through a registered issue stage; each issue tag is recorded in an in-order tag FIFO.
- Each cordic result (amp, phi) is routed back to the requester that issued the operand pair.
- Sits between the front-end sample producers and the cordic core in the amplitude/phase path.

Parameters:
- NB_REQ, 4, number of requesters (2..8).
- MAX_INFLIGHT, 8, maximum accepted-but-unanswered operations; also the tag FIFO depth (power of 2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- req_valid_i  in  NB_REQ  per-requester operand valid.
- req_ready_o  out  NB_REQ  per-requester operand ready (at most one bit set).
- req_re_i  in  NB_REQ*12  packed operands, slice k = [12k+11:12k], two's complement.
- req_im_i  in  NB_REQ*12  packed operands, same packing.
- rsp_valid_o  out  NB_REQ  per-requester result valid (at most one bit set).
- rsp_ready_i  in  NB_REQ  per-requester result ready.
- rsp_amp_o  out  12  result amplitude, broadcast to all requesters.
- rsp_phi_o  out  11  result phase, broadcast to all requesters.
- cor_re_o  out  12  operand to cordic re_i.
- cor_im_o  out  12  operand to cordic im_i.
- cor_valid_o  out  1  to cordic valid_i.
- cor_ready_i  in  1  from cordic ready_o.
- cor_amp_i  in  12  from cordic amp_o.
- cor_phi_i  in  11  from cordic phi_o.
- cor_valid_i  in  1  from cordic valid_o.
- cor_ready_o  out  1  to cordic ready_i.
- inflight_o  out  $clog2(MAX_INFLIGHT+1)  current outstanding count.
- err_o  out  1  sticky protocol error.

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-low (rst_ni).
- Reset values:
  - All outputs 0; req_ready_o = 0; rsp_valid_o = 0.
  - rr_ptr = 0; tag FIFO empty; inflight_o = 0; err_o = 0.
  - The issue register is cleared.
- Reset mid-operation discards all pending operations. The cordic is reset by the same reset net.

Issue side:
- can_accept = (inflight_o < MAX_INFLIGHT) && (!cor_valid_o || cor_ready_i).
- Grant g = first index k, scanning rr_ptr, rr_ptr+1, ... modulo NB_REQ, with req_valid_i[k] = 1.
- req_ready_o[g] = can_accept, combinational from the current inputs. All other req_ready_o bits are 0.
- No grant: req_ready_o = 0. rr_ptr is unchanged.
- On handshake with requester g, at the next edge:
  - cor_re_o/cor_im_o <= slice g; cor_valid_o <= 1.
  - Push g into the tag FIFO; inflight +1.
  - rr_ptr <= (g+1) mod NB_REQ.
- Issue register: cor_valid_o and the operands hold stable until cor_ready_i = 1.
  - cor_ready_i with no new grant: cor_valid_o <= 0.
  - cor_ready_i with a new grant: back-to-back issue, cor_valid_o stays 1.
- Throughput: 1 operation/cycle when the cordic is always ready.
- Latency: requester handshake to cor_valid_o is 1 cycle.
- Operands pass unmodified; the block does no arithmetic on re/im.

Response side:
- Let h = tag FIFO head.
- FIFO non-empty:
  - rsp_valid_o[h] = cor_valid_i; rsp_amp_o = cor_amp_i; rsp_phi_o = cor_phi_i. This path is combinational, 0 cycles.
  - cor_ready_o = rsp_ready_i[h].
  - Handshake (cor_valid_i && cor_ready_o): pop the FIFO; inflight -1.
- A stalled requester h blocks all responses (in-order cordic). Other requesters still issue until MAX_INFLIGHT is reached.
- FIFO empty and cor_valid_i = 1:
  - cor_ready_o = 1 (drain); the result is discarded.
  - rsp_valid_o = 0.
  - err_o <= 1 and stays 1 until reset.
- Accept and response handshake in the same cycle: inflight unchanged; push and pop both occur.
- inflight_o == MAX_INFLIGHT: req_ready_o = 0 until a response pops.
  - No same-cycle credit reuse: the count must drop first.
- The FIFO cannot overflow because push is gated by inflight < MAX_INFLIGHT.
- inflight_o equals the FIFO occupancy at all times.
- Pointers wrap modulo MAX_INFLIGHT.

Test Plan:
- Single requester: req 0 sends (1000, 500); cordic model returns after 10 cycles.
  - req_ready_o = 0001 for 1 cycle; cor_valid_o = 1 the next cycle.
  - rsp_valid_o = 0001 with the model's amp/phi; inflight_o goes 1 then 0.
- Round-robin: all 4 requesters valid continuously, cor_ready_i = 1.
  - Grant order 0,1,2,3,0,1 on consecutive cycles.
  - Responses are routed to requesters in the same order.
- Credit limit: MAX_INFLIGHT = 8, cordic holds cor_valid_i low.
  - Exactly 8 accepts, then req_ready_o = 0.
  - One response pop: inflight_o = 7, and one further accept occurs on the following cycle.
- Backpressure:
  - cor_ready_i held 0 for 5 cycles: cor_re_o/cor_im_o stay stable and only 1 operation is accepted.
  - rsp_ready_i[h] = 0: cor_ready_o = 0 and the FIFO head is unchanged.
- Error and reset:
  - cor_valid_i pulse with the FIFO empty: cor_ready_o = 1, err_o = 1 sticky, rsp_valid_o = 0.
  - rst_ni asserted with 3 in flight: all outputs 0 immediately (asynchronous), inflight_o = 0, err_o = 0.

Source files
------------

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one cordic core between NB_REQ requesters.
// Operands are granted round-robin into a registered issue stage; the
// granted index is queued in an in-order tag FIFO so each cordic result
// can be steered back to the requester that issued it.
module cordic_arbiter #(
  parameter int NB_REQ       = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NB_REQ-1:0]                 req_valid_i,
  output logic [NB_REQ-1:0]                 req_ready_o,
  input  logic [NB_REQ*12-1:0]              req_re_i,
  input  logic [NB_REQ*12-1:0]              req_im_i,
  output logic [NB_REQ-1:0]                 rsp_valid_o,
  input  logic [NB_REQ-1:0]                 rsp_ready_i,
  output logic [11:0]                       rsp_amp_o,
  output logic [10:0]                       rsp_phi_o,
  output logic [11:0]                       cor_re_o,
  output logic [11:0]                       cor_im_o,
  output logic                              cor_valid_o,
  input  logic                              cor_ready_i,
  input  logic [11:0]                       cor_amp_i,
  input  logic [10:0]                       cor_phi_i,
  input  logic                              cor_valid_i,
  output logic                              cor_ready_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
  output logic                              err_o
);

  localparam int TW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  localparam logic [TW:0]   NB_REQ_W = (TW + 1)'(NB_REQ);
  localparam logic [TW-1:0] LAST_REQ = TW'(NB_REQ - 1);
  localparam logic [CW-1:0] MAX_W    = CW'(MAX_INFLIGHT);

  // registered state
  logic [TW-1:0] rr_ptr_q, rr_ptr_d;
  logic          cor_valid_q, cor_valid_d;
  logic [11:0]   cor_re_q, cor_re_d;
  logic [11:0]   cor_im_q, cor_im_d;
  logic [TW-1:0] tag_mem_q [MAX_INFLIGHT];
  logic [TW-1:0] tag_mem_d [MAX_INFLIGHT];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          err_q, err_d;

  // combinational helpers
  logic          grant_vld;
  logic [TW-1:0] grant_idx;
  logic [TW:0]   cand_sum;
  logic [TW-1:0] cand;
  logic          can_accept;
  logic          accept;
  logic [11:0]   sel_re;
  logic [11:0]   sel_im;
  logic          fifo_empty;
  logic [TW-1:0] head_tag;
  logic          head_ready;
  logic          pop;
  logic          drain;

  // Round-robin search: first valid requester starting at rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (TW + 1)'(i);
      if (cand_sum >= NB_REQ_W) begin
        cand_sum = cand_sum - NB_REQ_W;
      end
      cand = cand_sum[TW-1:0];
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Credit and issue-slot check, ready to the granted requester, operand mux.
  // A new operand may enter only when the issue register is empty or is
  // being taken by the cordic this same cycle.
  always_comb begin
    can_accept  = (inflight_q < MAX_W) && (!cor_valid_q || cor_ready_i);
    accept      = rst_ni && grant_vld && can_accept;
    req_ready_o = '0;
    sel_re      = '0;
    sel_im      = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (grant_idx == TW'(k)) begin
        req_ready_o[k] = accept;
        sel_re         = req_re_i[12*k +: 12];
        sel_im         = req_im_i[12*k +: 12];
      end
    end
  end

  // Result routing: the FIFO head names the requester that owns the result
  // now on the cordic output. With nothing outstanding, any result is
  // drained and flagged as a protocol error.
  always_comb begin
    fifo_empty  = (inflight_q == '0);
    head_tag    = tag_mem_q[rd_ptr_q];
    head_ready  = 1'b0;
    rsp_valid_o = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (head_tag == TW'(k)) begin
        head_ready     = rsp_ready_i[k];
        rsp_valid_o[k] = rst_ni && !fifo_empty && cor_valid_i;
      end
    end
    cor_ready_o = rst_ni && (fifo_empty ? cor_valid_i : head_ready);
    rsp_amp_o   = fifo_empty ? '0 : cor_amp_i;
    rsp_phi_o   = fifo_empty ? '0 : cor_phi_i;
    pop         = rst_ni && !fifo_empty && cor_valid_i && head_ready;
    drain       = rst_ni && fifo_empty && cor_valid_i;
  end

  // Next-state for issue register, round-robin pointer, tag FIFO and counters.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cor_valid_d = cor_valid_q;
    cor_re_d    = cor_re_q;
    cor_im_d    = cor_im_q;
    tag_mem_d   = tag_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = inflight_q;
    err_d       = err_q | drain;

    if (accept) begin
      cor_valid_d          = 1'b1;
      cor_re_d             = sel_re;
      cor_im_d             = sel_im;
      rr_ptr_d             = (grant_idx == LAST_REQ) ? '0 : grant_idx + TW'(1);
      tag_mem_d[wr_ptr_q]  = grant_idx;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end else if (cor_ready_i) begin
      cor_valid_d = 1'b0;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({accept, pop})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers; reset discards every pending operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      cor_valid_q <= 1'b0;
      cor_re_q    <= '0;
      cor_im_q    <= '0;
      tag_mem_q   <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cor_valid_q <= cor_valid_d;
      cor_re_q    <= cor_re_d;
      cor_im_q    <= cor_im_d;
      tag_mem_q   <= tag_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end

  assign cor_valid_o = cor_valid_q;
  assign cor_re_o    = cor_re_q;
  assign cor_im_o    = cor_im_q;
  assign inflight_o  = inflight_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: directed stimulus, a small cordic model
// (amp = re, phi = im[10:0], fixed latency) and a response scoreboard.
module tb_cordic_arbiter;

  localparam int NB_REQ       = 4;
  localparam int MAX_INFLIGHT = 8;
  localparam int CW           = $clog2(MAX_INFLIGHT + 1);

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b1;
  logic [NB_REQ-1:0]    req_valid_i = '0;
  logic [NB_REQ-1:0]    req_ready_o;
  logic [NB_REQ*12-1:0] req_re_i = '0;
  logic [NB_REQ*12-1:0] req_im_i = '0;
  logic [NB_REQ-1:0]    rsp_valid_o;
  logic [NB_REQ-1:0]    rsp_ready_i = '1;
  logic [11:0]          rsp_amp_o;
  logic [10:0]          rsp_phi_o;
  logic [11:0]          cor_re_o;
  logic [11:0]          cor_im_o;
  logic                 cor_valid_o;
  logic                 cor_ready_i = 1'b1;
  logic [11:0]          cor_amp_i = '0;
  logic [10:0]          cor_phi_i = '0;
  logic                 cor_valid_i = 1'b0;
  logic                 cor_ready_o;
  logic [CW-1:0]        inflight_o;
  logic                 err_o;

  cordic_arbiter #(.NB_REQ(NB_REQ), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_re_i    (req_re_i),
    .req_im_i    (req_im_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_amp_o   (rsp_amp_o),
    .rsp_phi_o   (rsp_phi_o),
    .cor_re_o    (cor_re_o),
    .cor_im_o    (cor_im_o),
    .cor_valid_o (cor_valid_o),
    .cor_ready_i (cor_ready_i),
    .cor_amp_i   (cor_amp_i),
    .cor_phi_i   (cor_phi_i),
    .cor_valid_i (cor_valid_i),
    .cor_ready_o (cor_ready_o),
    .inflight_o  (inflight_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] re_tab [NB_REQ];
  logic [11:0] im_tab [NB_REQ];

  typedef struct {
    int          req;
    logic [11:0] amp;
    logic [10:0] phi;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void expect_rsp(int k);
    exp_t e;
    e.req = k;
    e.amp = re_tab[k];
    e.phi = im_tab[k][10:0];
    sb.push_back(e);
  endfunction

  // cordic model controls
  int   lat  = 1;
  logic hold = 1'b0;
  logic spur = 1'b0;

  typedef struct {
    logic [11:0] amp;
    logic [10:0] phi;
    int          due;
  } mdl_t;
  mdl_t        mq[$];
  mdl_t        m_e;
  int          cyc = 0;
  logic        m_in, m_out;
  logic        m_spur_out = 1'b0;
  logic [11:0] m_re;
  logic [10:0] m_im;

  // cordic model: handshakes observed at the falling edge take effect at the
  // following rising edge; outputs change just after that edge.
  always begin
    @(negedge clk_i);
    m_in  = cor_valid_o && cor_ready_i;
    m_out = cor_valid_i && cor_ready_o;
    m_re  = cor_re_o;
    m_im  = cor_im_o[10:0];
    @(posedge clk_i);
    cyc++;
    #1;
    if (!rst_ni) begin
      mq.delete();
    end else begin
      if (m_out && !m_spur_out && mq.size() > 0) void'(mq.pop_front());
      if (m_in) begin
        m_e.amp = m_re;
        m_e.phi = m_im;
        m_e.due = cyc + lat;
        mq.push_back(m_e);
      end
    end
    m_spur_out = 1'b0;
    if (spur && rst_ni) begin
      cor_valid_i = 1'b1;
      cor_amp_i   = 12'h7FF;
      cor_phi_i   = 11'h3FF;
      m_spur_out  = 1'b1;
    end else if (rst_ni && mq.size() > 0 && mq[0].due <= cyc && !hold) begin
      cor_valid_i = 1'b1;
      cor_amp_i   = mq[0].amp;
      cor_phi_i   = mq[0].phi;
    end else begin
      cor_valid_i = 1'b0;
      cor_amp_i   = '0;
      cor_phi_i   = '0;
    end
  end

  // response monitor: every accepted result must match the scoreboard head
  always @(negedge clk_i) begin
    if (rst_ni && ((rsp_valid_o & rsp_ready_i) != '0)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: rsp_valid_o=0x%0h with no response expected", rsp_valid_o);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_route", 32'(rsp_valid_o), 32'(1) << mon_e.req);
        check("rsp_amp", 32'(rsp_amp_o), 32'(mon_e.amp));
        check("rsp_phi", 32'(rsp_phi_o), 32'(mon_e.phi));
      end
    end
  end

  task automatic drive(input logic [NB_REQ-1:0] mask);
    req_valid_i = mask;
    for (int k = 0; k < NB_REQ; k++) begin
      req_re_i[12*k +: 12] = re_tab[k];
      req_im_i[12*k +: 12] = im_tab[k];
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni      = 1'b0;
    drive('0);
    rsp_ready_i = '1;
    cor_ready_i = 1'b1;
    hold        = 1'b0;
    spur        = 1'b0;
    repeat (2) @(negedge clk_i);
    sb.delete();
    rst_ni = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || inflight_o != '0) && n < budget) begin
      smp();
      n++;
    end
    check({name, "_sb_empty"}, 32'(sb.size()), 32'(0));
    check({name, "_inflight_zero"}, 32'(inflight_o), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    re_tab = '{12'd1000, 12'h2B2, 12'h7F3, 12'h804};
    im_tab = '{12'd500,  12'h15A, 12'h3C3, 12'hE3C};

    // reset state, with all requesters asking
    #2 rst_ni = 1'b0;
    drive(4'hF);
    smp();
    check("rst_req_ready", 32'(req_ready_o), 32'(0));
    check("rst_cor_valid", 32'(cor_valid_o), 32'(0));
    check("rst_inflight", 32'(inflight_o), 32'(0));
    check("rst_err", 32'(err_o), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'(0));
    check("rst_cor_ready", 32'(cor_ready_o), 32'(0));
    drive('0);
    smp();
    rst_ni = 1'b1;

    // single requester, 10-cycle cordic
    lat = 10;
    step(); drive(4'b0001);
    smp();
    check("t1_ready", 32'(req_ready_o), 32'(4'b0001));
    expect_rsp(0);
    step(); drive('0);
    smp();
    check("t1_cor_valid", 32'(cor_valid_o), 32'(1));
    check("t1_cor_re", 32'(cor_re_o), 32'(12'd1000));
    check("t1_cor_im", 32'(cor_im_o), 32'(12'd500));
    check("t1_inflight_1", 32'(inflight_o), 32'(1));
    check("t1_ready_off", 32'(req_ready_o), 32'(0));
    n = 0;
    while (rsp_valid_o == '0 && n < 30) begin smp(); n++; end
    check("t1_rsp_valid", 32'(rsp_valid_o), 32'(4'b0001));
    check("t1_inflight_rsp", 32'(inflight_o), 32'(1));
    smp();
    check("t1_inflight_0", 32'(inflight_o), 32'(0));
    wait_drain("t1", 20);

    // round robin, everyone valid, cordic always ready
    do_reset();
    lat = 3;
    step(); drive(4'hF);
    for (int i = 0; i < 6; i++) begin
      smp();
      check("t2_grant", 32'(req_ready_o), 32'(1) << (i % 4));
      expect_rsp(i % 4);
      step();
    end
    drive('0);
    smp();
    check("t2_last_issue", 32'(cor_re_o), 32'(re_tab[1]));
    wait_drain("t2", 40);

    // credit limit with the cordic output held back
    do_reset();
    lat  = 1;
    hold = 1'b1;
    step(); drive(4'hF);
    for (int i = 0; i < 10; i++) begin
      smp();
      check("t3_ready", 32'(req_ready_o), (i < 8) ? (32'(1) << (i % 4)) : 32'(0));
      if (i < 8) expect_rsp(i % 4);
      step();
    end
    rsp_ready_i = 4'b0001;
    smp();
    check("t3_full", 32'(inflight_o), 32'(8));
    hold = 1'b0;
    n = 0;
    while (rsp_valid_o == '0 && n < 10) begin smp(); n++; end
    check("t3_first_rsp", 32'(rsp_valid_o), 32'(4'b0001));
    check("t3_no_reuse", 32'(req_ready_o), 32'(0));
    check("t3_cor_ready", 32'(cor_ready_o), 32'(1));
    smp();
    check("t3_inflight_7", 32'(inflight_o), 32'(7));
    check("t3_reaccept", 32'(req_ready_o), 32'(4'b0001));
    expect_rsp(0);
    check("t3_head_block", 32'(cor_ready_o), 32'(0));
    smp();
    check("t3_refull", 32'(inflight_o), 32'(8));
    check("t3_ready_off", 32'(req_ready_o), 32'(0));
    check("t3_head_same", 32'(rsp_valid_o), 32'(4'b0010));
    check("t3_head_block2", 32'(cor_ready_o), 32'(0));
    step(); drive('0); rsp_ready_i = '1;
    wait_drain("t3", 60);

    // cordic input backpressure
    do_reset();
    lat = 1;
    step(); cor_ready_i = 1'b0; drive(4'b1010);
    smp();
    check("t4_grant1", 32'(req_ready_o), 32'(4'b0010));
    expect_rsp(1);
    for (int i = 0; i < 5; i++) begin
      step();
      smp();
      check("t4_stall_ready", 32'(req_ready_o), 32'(0));
      check("t4_stall_valid", 32'(cor_valid_o), 32'(1));
      check("t4_stall_re", 32'(cor_re_o), 32'(re_tab[1]));
      check("t4_stall_im", 32'(cor_im_o), 32'(im_tab[1]));
      check("t4_stall_inflight", 32'(inflight_o), 32'(1));
    end
    step(); cor_ready_i = 1'b1;
    smp();
    check("t4_grant3", 32'(req_ready_o), 32'(4'b1000));
    expect_rsp(3);
    step(); drive('0);
    smp();
    check("t4_b2b_valid", 32'(cor_valid_o), 32'(1));
    check("t4_b2b_re", 32'(cor_re_o), 32'(re_tab[3]));
    wait_drain("t4", 30);

    // spurious cordic result with nothing outstanding
    do_reset();
    spur = 1'b1;
    smp();
    check("t5_drain_ready", 32'(cor_ready_o), 32'(1));
    check("t5_no_rsp", 32'(rsp_valid_o), 32'(0));
    check("t5_err_pre", 32'(err_o), 32'(0));
    spur = 1'b0;
    smp();
    check("t5_err_set", 32'(err_o), 32'(1));
    repeat (3) smp();
    check("t5_err_sticky", 32'(err_o), 32'(1));
    step(); drive(4'b0100);
    smp();
    check("t5_grant2", 32'(req_ready_o), 32'(4'b0100));
    expect_rsp(2);
    step(); drive('0);
    wait_drain("t5", 30);
    check("t5_err_still", 32'(err_o), 32'(1));

    // asynchronous reset with three operations outstanding
    hold = 1'b1;
    step(); drive(4'b0111);
    for (int i = 0; i < 3; i++) begin
      smp();
      step();
    end
    drive('0);
    smp();
    check("t6_inflight_3", 32'(inflight_o), 32'(3));
    step(); drive(4'hF);
    smp();
    #1 rst_ni = 1'b0;
    #1;
    check("t6_req_ready", 32'(req_ready_o), 32'(0));
    check("t6_cor_valid", 32'(cor_valid_o), 32'(0));
    check("t6_cor_re", 32'(cor_re_o), 32'(0));
    check("t6_cor_im", 32'(cor_im_o), 32'(0));
    check("t6_inflight", 32'(inflight_o), 32'(0));
    check("t6_err", 32'(err_o), 32'(0));
    check("t6_rsp_valid", 32'(rsp_valid_o), 32'(0));
    check("t6_cor_ready", 32'(cor_ready_o), 32'(0));
    smp();
    drive('0);
    hold = 1'b0;
    smp();
    rst_ni = 1'b1;
    step(); drive(4'b0001);
    smp();
    check("t6_post_grant", 32'(req_ready_o), 32'(4'b0001));
    expect_rsp(0);
    step(); drive('0);
    wait_drain("t6", 30);
    check("t6_post_err", 32'(err_o), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
